// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and helpers for the tic-tac-toe move sequencer.
// Sequencer FSM states, cell constants and a board cell-field extractor.
package ttt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    WAIT_CELL,
    RELEASE,
    DONE
  } seq_state_e;

  localparam int         NUM_CELLS      = 9;
  localparam logic [1:0] CELL_EMPTY     = 2'b00;
  localparam logic [3:0] MAX_MOVES      = 4'd9;
  // last WAIT_CELL cycle index before giving up on the cell write
  localparam logic [2:0] CELL_WAIT_LAST = 3'd3;

  // cell k of an 18-bit board lives at cells[2k+1:2k]
  function automatic logic [1:0] cell_at(
    input logic [17:0] cells,
    input logic [3:0]  k
  );
    logic [17:0] sh;
    sh = cells >> {k, 1'b0};
    return sh[1:0];
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchroniser plus stable-counter for the switches.
// Ports: clk, Reset (sync, high), raw_in[8:0] async switches, db[8:0] debounced.
import ttt_pkg::*;

module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [NUM_CELLS-1:0] raw_in,
  output logic [NUM_CELLS-1:0] db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CELLS-1:0] sync1_q, sync1_d;
  logic [NUM_CELLS-1:0] sync2_q, sync2_d;
  logic [NUM_CELLS-1:0] cand_q, cand_d;
  logic [NUM_CELLS-1:0] db_q, db_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // cand_q is the previous synced sample; cnt_q counts how long it has held
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    cand_d  = sync2_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (sync2_q != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      db_d = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: turn controller between the board switches and the cells.
// Ports: clk, Reset (sync, high), In[8:0] switches, Cells[17:0] board,
// winState; out sqrSel[8:0] strobe, Turn, moveCount[3:0], illegal,
// gameOver, draw. Optional MOVE_TIMEOUT_EN adds an idle-turn forfeit.
import ttt_pkg::*;

module move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [NUM_CELLS-1:0] In,
  input  logic [17:0]          Cells,
  input  logic                 winState,
  output logic [NUM_CELLS-1:0] sqrSel,
  output logic                 Turn,
  output logic [3:0]           moveCount,
  output logic                 illegal,
  output logic                 gameOver,
  output logic                 draw
);

  logic [NUM_CELLS-1:0] db;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk   (clk),
    .Reset (Reset),
    .raw_in(In),
    .db    (db)
  );

  seq_state_e state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [2:0] wait_q, wait_d;
  logic       turn_q, turn_d;
  logic [3:0] moves_q, moves_d;
  logic       illegal_q, illegal_d;
  logic       over_q, over_d;
  logic       draw_q, draw_d;

`ifdef MOVE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  logic [3:0] press_idx;
  logic       multi;
  logic [1:0] press_cell;
  logic [1:0] sel_cell;

  // only meaningful when exactly one bit of db is set
  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (db[i]) press_idx = 4'(i);
    end
  end

  assign multi      = |(db & (db - 1'b1));
  assign press_cell = cell_at(Cells, press_idx);
  assign sel_cell   = cell_at(Cells, sel_q);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    turn_d    = turn_q;
    moves_d   = moves_q;
    illegal_d = 1'b0;
    over_d    = winState | (moves_q == MAX_MOVES);
    draw_d    = (moves_q == MAX_MOVES) & ~winState;
`ifdef MOVE_TIMEOUT_EN
    idle_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (over_q) begin
          state_d = DONE;
        end else if (db == '0) begin
`ifdef MOVE_TIMEOUT_EN
          if (idle_q == IDLE_LAST) begin
            turn_d = ~turn_q;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end else if (multi || press_cell != CELL_EMPTY) begin
          illegal_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          sel_d   = press_idx;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        wait_d  = '0;
        state_d = WAIT_CELL;
      end
      WAIT_CELL: begin
        if (sel_cell != CELL_EMPTY) begin
          turn_d = ~turn_q;
          if (moves_q != MAX_MOVES) moves_d = moves_q + 1'b1;
          state_d = RELEASE;
        end else if (wait_q == CELL_WAIT_LAST) begin
          state_d = RELEASE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RELEASE: begin
        if (db == '0) state_d = IDLE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      wait_q    <= '0;
      turn_q    <= 1'b0;
      moves_q   <= '0;
      illegal_q <= 1'b0;
      over_q    <= 1'b0;
      draw_q    <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      turn_q    <= turn_d;
      moves_q   <= moves_d;
      illegal_q <= illegal_d;
      over_q    <= over_d;
      draw_q    <= draw_d;
`ifdef MOVE_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  // strobe decoded from state so a reset drops it on the very next edge
  assign sqrSel    = (state_q == COMMIT) ?
                     (NUM_CELLS'(1) << sel_q) : '0;
  assign Turn      = turn_q;
  assign moveCount = moves_q;
  assign illegal   = illegal_q;
  assign gameOver  = over_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized directed bench with a board/turn model.
// Drives switch presses, models the cell array and checks strobes/status.
module tb_move_sequencer;

  localparam int DBC = 4;
  localparam int TOC = 50;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [8:0] In = '0;
  logic [17:0] Cells;
  logic       winState = 1'b0;
  logic [8:0] sqrSel;
  logic       Turn;
  logic [3:0] moveCount;
  logic       illegal;
  logic       gameOver;
  logic       draw;

  logic [1:0] board [9];
  int  checks = 0;
  int  errors = 0;
  bit  cell_we = 1'b1;
  int  strobe_n = 0;
  int  ill_n = 0;
  logic [8:0] last_sel = '0;

  bit m_turn = 1'b0;
  int m_moves = 0;
  bit m_win = 1'b0;
  bit m_over = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    Cells = '0;
    for (int i = 0; i < 9; i++) Cells[2*i +: 2] = board[i];
  end

  move_sequencer #(
    .DEBOUNCE_CYCLES(DBC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .In       (In),
    .Cells    (Cells),
    .winState (winState),
    .sqrSel   (sqrSel),
    .Turn     (Turn),
    .moveCount(moveCount),
    .illegal  (illegal),
    .gameOver (gameOver),
    .draw     (draw)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cell model: the strobed cell gets the mover's mark half a cycle later
  always @(negedge clk) begin
    if (sqrSel !== 9'h0) begin
      strobe_n++;
      last_sel = sqrSel;
      check("onehot", {31'b0, $onehot(sqrSel)}, 32'd1);
      if (cell_we) begin
        for (int i = 0; i < 9; i++)
          if (sqrSel[i]) board[i] = m_turn ? 2'b10 : 2'b01;
      end
    end
    if (illegal === 1'b1) ill_n++;
  end

  task automatic new_game();
    Reset = 1'b1;
    In = '0;
    winState = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) board[i] = 2'b00;
    m_turn = 1'b0;
    m_moves = 0;
    m_win = 1'b0;
    m_over = 1'b0;
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [8:0] mask, input int hold,
                       input string tag);
    int  e_str, e_ill, k;
    bit  e_turn;
    int  e_moves;
    e_str = 0;
    e_ill = 0;
    e_turn = m_turn;
    e_moves = m_moves;
    k = 0;
    for (int i = 0; i < 9; i++) if (mask[i]) k = i;
    if (!m_over) begin
      if ($countones(mask) != 1 || board[k] != 2'b00) begin
        e_ill = 1;
      end else begin
        e_str = 1;
        if (cell_we) begin
          e_turn = ~m_turn;
          e_moves = (m_moves < 9) ? m_moves + 1 : 9;
        end
      end
    end
    strobe_n = 0;
    ill_n = 0;
    last_sel = '0;
    In = mask;
    repeat (hold) @(negedge clk);
    In = '0;
    repeat (16) @(negedge clk);
    m_turn = e_turn;
    m_moves = e_moves;
    m_over = m_win || (m_moves == 9);
    check({tag, "_strobes"}, strobe_n, e_str);
    check({tag, "_illegal"}, ill_n, e_ill);
    if (e_str == 1) check({tag, "_sel"}, last_sel, mask);
    check({tag, "_turn"}, Turn, m_turn);
    check({tag, "_count"}, moveCount, m_moves);
    check({tag, "_over"}, gameOver, m_over);
    check({tag, "_draw"}, draw, m_moves == 9 && !m_win);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  q[$];
    int  n;
    bit  seen;
    logic [8:0] m;

    for (int i = 0; i < 9; i++) board[i] = 2'b00;
    new_game();
    check("rst_sel", sqrSel, 0);
    check("rst_turn", Turn, 0);
    check("rst_count", moveCount, 0);
    check("rst_illegal", illegal, 0);
    check("rst_over", gameOver, 0);
    check("rst_draw", draw, 0);

    press(9'h010, 20, "hold");
    press(9'h010, 12, "occupied");
    press(9'h003, 12, "multi");
    press(9'h001, 12, "after_multi");

    strobe_n = 0;
    ill_n = 0;
    In = 9'h004;
    repeat (2) @(negedge clk);
    In = '0;
    repeat (16) @(negedge clk);
    check("glitch_strobes", strobe_n, 0);
    check("glitch_illegal", ill_n, 0);

    cell_we = 1'b0;
    press(9'h100, 12, "no_cell");
    cell_we = 1'b1;

    n = 0;
    while (!m_over && n < 60) begin
      if ($urandom_range(0, 3) == 0) begin
        m = 9'($urandom_range(1, 511));
      end else begin
        q.delete();
        for (int i = 0; i < 9; i++) if (board[i] == 2'b00) q.push_back(i);
        m = 9'h001 << q[$urandom_range(0, q.size() - 1)];
      end
      press(m, $urandom_range(10, 20), "rand");
      n++;
    end
    check("full_over", gameOver, 1);
    check("full_draw", draw, 1);
    check("full_count", moveCount, 9);
    press(9'h001 << $urandom_range(0, 8), 12, "after_full");

    new_game();
    for (int j = 0; j < 5; j++) begin
      q.delete();
      for (int i = 0; i < 9; i++) if (board[i] == 2'b00) q.push_back(i);
      m = 9'h001 << q[$urandom_range(0, q.size() - 1)];
      press(m, 12, "win_move");
    end
    winState = 1'b1;
    m_win = 1'b1;
    m_over = 1'b1;
    repeat (3) @(negedge clk);
    check("win_over", gameOver, 1);
    check("win_draw", draw, 0);
    q.delete();
    for (int i = 0; i < 9; i++) if (board[i] == 2'b00) q.push_back(i);
    press(9'h001 << q[0], 12, "after_win");

    new_game();
    In = 9'h040;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (sqrSel != 9'h0);
    end
    check("wait_strobe_seen", seen, 1);
    @(negedge clk);
    Reset = 1'b1;
    In = '0;
    @(negedge clk);
    check("midrst_sel", sqrSel, 0);
    check("midrst_turn", Turn, 0);
    check("midrst_count", moveCount, 0);
    check("midrst_illegal", illegal, 0);
    check("midrst_over", gameOver, 0);
    check("midrst_draw", draw, 0);
    new_game();

`ifdef MOVE_TIMEOUT_EN
    repeat (60) @(negedge clk);
    check("timeout_turn", Turn, 1);
    check("timeout_count", moveCount, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
